// File: rtl/sub_serial_if.sv
// Handshake and operand bus for the bit-serial subtractor.
// The master starts an operation and reads back the difference and borrow.
interface sub_serial_if #(parameter int WIDTH = 8);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             borrow;
    logic             done;

    modport master (output en, a, b, input out, borrow, done);
    modport slave  (input en, a, b, output out, borrow, done);
endinterface

// File: rtl/sub_serial.sv
// Bit-serial subtractor: out = a - b mod 2^WIDTH, one bit per clock, LSB first.
// Shares the en-driven IDLE/compute/DONE handshake with the serial adder.
//
// state | meaning
// IDLE  | waiting for en; operands are loaded on the en edge
// SUB   | one difference bit per edge, WIDTH edges total
// DONE  | result and final borrow valid; en returns to IDLE
module sub_serial #(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    sub_serial_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] out_r;
    logic             borrow_r;
    logic [CW-1:0]    count;
    logic             d;
    logic             borrow_nxt;

    always_comb begin
        d          = a_reg[0] ^ b_reg[0] ^ borrow_r;
        borrow_nxt = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & borrow_r) | (b_reg[0] & borrow_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            out_r    <= '0;
            borrow_r <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        a_reg    <= bus.a;
                        b_reg    <= bus.b;
                        out_r    <= '0;
                        borrow_r <= 1'b0;
                        count    <= '0;
                        state    <= SUB;
                    end
                end
                SUB: begin
                    // New bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
                    out_r    <= {d, out_r[WIDTH-1:1]};
                    borrow_r <= borrow_nxt;
                    a_reg    <= {1'b0, a_reg[WIDTH-1:1]};
                    b_reg    <= {1'b0, b_reg[WIDTH-1:1]};
                    count    <= count + 1'b1;
                    if (count == CW'(WIDTH - 1))
                        state <= DONE;
                end
                DONE: begin
                    if (bus.en)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out    = out_r;
    assign bus.borrow = borrow_r;
    assign bus.done   = (state == DONE);
endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial: hand-computed differences, latency, reset abort,
// input noise during SUB and back-to-back operation with en held high.
module tb_sub_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_asserts = 0;
    int   n_fails = 0;
    int   n_edges;

    sub_serial_if #(.WIDTH(8)) bus ();

    sub_serial #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for done after the start edge; n = edges after E0, 99 on timeout.
    task automatic wait_done(output int n);
        n = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        bus.a  = a;
        bus.b  = b;
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
    endtask

    task automatic release_done();
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        check("release_done", {31'd0, bus.done}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_out, input logic exp_borrow);
        start_op(a, b);
        wait_done(n_edges);
        check({tag, "_latency"}, n_edges + 1, 32'd9);
        check({tag, "_out"}, {24'd0, bus.out}, {24'd0, exp_out});
        check({tag, "_borrow"}, {31'd0, bus.borrow}, {31'd0, exp_borrow});
        release_done();
    endtask

    initial begin
        bus.en = 1'b0;
        bus.a  = 8'h00;
        bus.b  = 8'h00;
        #12;
        check("rst_out", {24'd0, bus.out}, 32'd0);
        check("rst_borrow", {31'd0, bus.borrow}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of SUB aborts and clears immediately.
        start_op(8'h5A, 8'h11);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midsub_rst_out", {24'd0, bus.out}, 32'd0);
        check("midsub_rst_borrow", {31'd0, bus.borrow}, 32'd0);
        check("midsub_rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("idle_after_rst_done", {31'd0, bus.done}, 32'd0);
        check("idle_after_rst_out", {24'd0, bus.out}, 32'd0);

        run_op("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0);
        run_op("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1);
        run_op("sub_00_ff", 8'h00, 8'hFF, 8'h01, 1'b1);
        run_op("sub_ff_01", 8'hFF, 8'h01, 8'hFE, 1'b0);
        run_op("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0);

        // Operands and en wiggled every cycle during SUB must be ignored.
        start_op(8'h80, 8'h01);
        n_edges = 99;
        for (int i = 1; i <= 20; i++) begin
            bus.en = ~bus.en;
            bus.a  = 8'($urandom);
            bus.b  = 8'($urandom);
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                n_edges = i;
                break;
            end
        end
        bus.en = 1'b0;
        check("noise_latency", n_edges + 1, 32'd9);
        check("noise_out", {24'd0, bus.out}, 32'h7F);
        check("noise_borrow", {31'd0, bus.borrow}, 32'd0);
        @(posedge clk);
        #1;
        check("done_holds", {31'd0, bus.done}, 32'd1);
        check("done_holds_out", {24'd0, bus.out}, 32'h7F);
        release_done();

        // en held high across two operations.
        bus.a  = 8'h10;
        bus.b  = 8'h01;
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 8'h01;
        bus.b = 8'h02;
        wait_done(n_edges);
        check("b2b1_latency", n_edges + 1, 32'd9);
        check("b2b1_out", {24'd0, bus.out}, 32'h0F);
        check("b2b1_borrow", {31'd0, bus.borrow}, 32'd0);
        @(posedge clk);
        #1;
        check("b2b_gap_done", {31'd0, bus.done}, 32'd0);
        check("b2b_gap_out_persists", {24'd0, bus.out}, 32'h0F);
        @(posedge clk);
        #1;
        check("b2b_restart_clears_out", {24'd0, bus.out}, 32'd0);
        wait_done(n_edges);
        check("b2b2_latency", n_edges, 32'd8);
        check("b2b2_out", {24'd0, bus.out}, 32'hFF);
        check("b2b2_borrow", {31'd0, bus.borrow}, 32'd1);
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        check("b2b2_done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("b2b2_out_persists", {24'd0, bus.out}, 32'hFF);
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_done", {31'd0, bus.done}, 32'd0);
        check("idle_hold_borrow", {31'd0, bus.borrow}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule

// File: doc/sub_serial.md
# sub_serial

Bit-serial 8-bit subtractor that computes out = a − b (mod 2^WIDTH) one bit per clock, LSB first, with a borrow chain. It is the inverse companion of the serial adder in the same arithmetic datapath: feeding it an adder result and one original operand recovers the other operand. It uses the same en-driven IDLE/compute/DONE protocol, so both blocks can share one sequencer.

## Interface
- WIDTH, 8, operand and result width in bits; count register is clog2(WIDTH) bits wide.
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  start request in IDLE; acknowledge/release in DONE.
- a  input  WIDTH  minuend, sampled only on the IDLE-and-en edge.
- b  input  WIDTH  subtrahend, sampled only on the IDLE-and-en edge.
- out  output  WIDTH  difference register, shifted in MSB-side, LSB first.
- borrow  output  1  running borrow; holds the final borrow (1 iff a < b unsigned) in DONE.
- done  output  1  high exactly while the state is DONE.

## Operation
- States: IDLE=2'd0, SUB=2'd1, DONE=2'd2. Encoding 2'd3 is unreachable and returns to IDLE on the next edge with no register change.
- Internal registers: a_reg, b_reg (WIDTH), count, state. The borrow register drives the borrow output.
- IDLE, en=1: a_reg←a, b_reg←b, out←0, borrow←0, count←0, state→SUB.
- IDLE, en=0: hold all registers.
- SUB, each edge:
  - d = a_reg[0] ^ b_reg[0] ^ borrow.
  - borrow ← (~a_reg[0] & b_reg[0]) | (~a_reg[0] & borrow) | (b_reg[0] & borrow).
  - out ← {d, out[WIDTH-1:1]}.
  - a_reg, b_reg logical shift right by 1; count ← count+1.
  - State: count==WIDTH-1 → DONE, else stay in SUB.
- SUB ignores en, a and b entirely.
- DONE: out, borrow and count hold.
  - en=1 → IDLE.
  - en=0 → stay in DONE.
- done = (state==DONE), decoded combinationally from the state register.
- Arithmetic: the result wraps modulo 2^WIDTH. No sign interpretation; borrow is the only overflow indication.

## Timing
- Reset values: out=0, borrow=0, done=0, state=IDLE, count=0, a_reg=b_reg=0. Reset takes effect immediately, including mid-SUB, and aborts the operation.
- Edge E0 (IDLE, en=1) loads the operands. SUB occupies edges E1..EWIDTH. State becomes DONE after edge EWIDTH (E8 for the default).
  - out and borrow are final and done rises after E8.
  - Start-to-done latency is WIDTH+1 edges.
- Intermediate out values are partial and are valid only when done=1.
- en held high continuously: DONE→IDLE on one edge, then IDLE→SUB on the next. The restart gap is 2 edges, and done is high for 1 cycle.
- en pulsed during SUB has no effect and is not queued.
- Leaving DONE does not clear out or borrow. They persist through IDLE until the next start edge clears them.

## Test plan
- Reset: assert rst mid-SUB with a=0x5A, b=0x11. Required: out=0, borrow=0, done=0 immediately; after release the block idles until en.
- a=0x05, b=0x03, en pulse. Required: done high after exactly 9 edges from start; out=0x02, borrow=0.
- a=0x03, b=0x05. Required: out=0xFE, borrow=1.
- a=0x00, b=0xFF, then a=0xFF, b=0x01, then a=b=0x00. Required: 0x01/borrow=1, 0xFE/0, 0x00/0.
- Change a and b and toggle en every cycle during SUB with a=0x80, b=0x01. Required: out=0x7F, borrow=0, done timing unchanged.
- en held high across two operations (0x10−0x01, then 0x01−0x02). Required: 0x0F/0, then 0xFF/1; done high one cycle each; 2-edge gap between DONE and the next SUB.
